// File: rtl/sgmii_pkg.sv
// Shared constants, state encoding and defaults for the SGMII receive word aligner.
package sgmii_pkg;

    // Comma character that marks the 10-bit word boundary.
    localparam logic [7:0] K28_5 = 8'hBC;

    // Default tuning values.
    localparam int DEF_HUNT_WINDOW  = 32;
    localparam int DEF_SLIP_PULSE_W = 2;
    localparam int DEF_SETTLE_CYC   = 6;
    localparam int DEF_ACQ_COMMAS   = 3;
    localparam int DEF_LOSS_ERRS    = 4;
    localparam int DEF_GOOD_RECOVER = 4;

    // Alignment controller states. The encoding is visible on the debug state port.
    typedef enum logic [2:0] {
        HUNT   = 3'd0,
        SLIP   = 3'd1,
        SETTLE = 3'd2,
        VERIFY = 3'd3,
        SYNCED = 3'd4
    } alignState_t;

    // Increment a 4-bit count, holding at 15.
    function automatic logic [3:0] satInc4(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/sgmii_sync_err_monitor.sv
// Error / good-streak bookkeeping used while word alignment is held.
// The error count rises on every invalid group and is worked back down by
// runs of good groups; the loss request fires combinationally in the cycle
// the count would reach the loss threshold, so the controller can leave
// SYNCED on the very next edge.
module sgmii_sync_err_monitor
    import sgmii_pkg::*;
#(
    parameter int LOSS_ERRS    = DEF_LOSS_ERRS,
    parameter int GOOD_RECOVER = DEF_GOOD_RECOVER
) (
    input  logic i_Clk,
    input  logic i_ARst_L,
    input  logic i_Clear,
    input  logic i_GroupValid,
    input  logic i_GroupInvalid,
    output logic o_LossReq
);

    localparam int ERR_W    = $clog2(LOSS_ERRS + 1);
    localparam int STREAK_W = $clog2(GOOD_RECOVER + 1);

    localparam logic [ERR_W-1:0]    ERR_MAX    = ERR_W'(LOSS_ERRS);
    localparam logic [ERR_W-1:0]    ERR_ONE    = ERR_W'(1);
    localparam logic [ERR_W-1:0]    ERR_ZERO   = '0;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(GOOD_RECOVER);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    logic [ERR_W-1:0]    errCnt;
    logic [ERR_W-1:0]    errNext;
    logic [STREAK_W-1:0] streak;
    logic [STREAK_W-1:0] streakNext;

    // Next error count and good streak for the current group.
    always_comb begin
        errNext    = errCnt;
        streakNext = streak;
        if (i_Clear) begin
            errNext    = '0;
            streakNext = '0;
        end else if (i_GroupValid) begin
            if (i_GroupInvalid) begin
                if (errCnt != ERR_MAX) begin
                    errNext = errCnt + ERR_ONE;
                end
                streakNext = '0;
            end else if (errCnt != ERR_ZERO) begin
                if (streak == STREAK_MAX - STREAK_ONE) begin
                    errNext    = errCnt - ERR_ONE;
                    streakNext = '0;
                end else begin
                    streakNext = streak + STREAK_ONE;
                end
            end else if (streak != STREAK_MAX) begin
                streakNext = streak + STREAK_ONE;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            errCnt <= '0;
            streak <= '0;
        end else begin
            errCnt <= errNext;
            streak <= streakNext;
        end
    end

    assign o_LossReq = !i_Clear && i_GroupValid && i_GroupInvalid && (errNext == ERR_MAX);

endmodule

// File: rtl/sgmii_rx_word_aligner.sv
// Receive word-alignment controller: hunts for K28.5, pulses the PHY bit-slip
// input until commas sit on the word boundary, verifies a run of commas and
// then holds sync until the error monitor reports loss.
// Handshake note: there is no valid/ready flow here; every cycle carries one
// decoded code group and all outputs are Moore decodes of registered state.
module sgmii_rx_word_aligner
    import sgmii_pkg::*;
#(
    parameter int HUNT_WINDOW  = DEF_HUNT_WINDOW,
    parameter int SLIP_PULSE_W = DEF_SLIP_PULSE_W,
    parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int ACQ_COMMAS   = DEF_ACQ_COMMAS,
    parameter int LOSS_ERRS    = DEF_LOSS_ERRS,
    parameter int GOOD_RECOVER = DEF_GOOD_RECOVER
) (
    input  logic       i_Clk,
    input  logic       i_ARst_L,
    input  logic       i_Enable,
    input  logic [7:0] i8_RxCodeGroup,
    input  logic       i_RxCodeCtrl,
    input  logic       i_RxCodeInvalid,
    output logic       o_RxBitSlip,
    output logic       o_SyncAcquired,
    output logic       o_LossOfSync,
    output logic [3:0] o4_SlipCount,
    output logic [2:0] o3_DbgState
);

    localparam int WIN_W   = $clog2(HUNT_WINDOW);
    localparam int COMMA_W = $clog2(ACQ_COMMAS + 1);
    localparam int TMR_MAX = (SLIP_PULSE_W > SETTLE_CYC) ? SLIP_PULSE_W : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [WIN_W-1:0]   WIN_LAST    = WIN_W'(HUNT_WINDOW - 1);
    localparam logic [WIN_W-1:0]   WIN_ONE     = WIN_W'(1);
    localparam logic [COMMA_W-1:0] COMMA_LAST  = COMMA_W'(ACQ_COMMAS - 1);
    localparam logic [COMMA_W-1:0] COMMA_ONE   = COMMA_W'(1);
    localparam logic [TMR_W-1:0]   SLIP_LAST   = TMR_W'(SLIP_PULSE_W - 1);
    localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0]   TMR_ONE     = TMR_W'(1);

    alignState_t        state;
    alignState_t        stateNext;
    logic [WIN_W-1:0]   windowCnt;
    logic [WIN_W-1:0]   windowNext;
    logic [COMMA_W-1:0] commaCnt;
    logic [COMMA_W-1:0] commaNext;
    logic [TMR_W-1:0]   slipTmr;
    logic [TMR_W-1:0]   slipTmrNext;
    logic [3:0]         slipCnt;
    logic [3:0]         slipCntNext;
    logic               lossPulse;
    logic               lossPulseNext;

    logic goodComma;
    logic monClear;
    logic monLossReq;

    assign goodComma = i_RxCodeCtrl && (i8_RxCodeGroup == K28_5) && !i_RxCodeInvalid;
    assign monClear  = !i_Enable || (state != SYNCED);

    sgmii_sync_err_monitor #(
        .LOSS_ERRS    (LOSS_ERRS),
        .GOOD_RECOVER (GOOD_RECOVER)
    ) u_errMon (
        .i_Clk          (i_Clk),
        .i_ARst_L       (i_ARst_L),
        .i_Clear        (monClear),
        .i_GroupValid   (state == SYNCED),
        .i_GroupInvalid (i_RxCodeInvalid),
        .o_LossReq      (monLossReq)
    );

    // Next-state and counter update for the alignment controller.
    always_comb begin
        stateNext     = state;
        windowNext    = windowCnt;
        commaNext     = commaCnt;
        slipTmrNext   = slipTmr;
        slipCntNext   = slipCnt;
        lossPulseNext = 1'b0;
        if (!i_Enable) begin
            stateNext   = HUNT;
            windowNext  = '0;
            commaNext   = '0;
            slipTmrNext = '0;
            slipCntNext = '0;
        end else begin
            case (state)
                HUNT: begin
                    if (goodComma) begin
                        stateNext  = VERIFY;
                        commaNext  = COMMA_ONE;
                        windowNext = '0;
                    end else if (windowCnt == WIN_LAST) begin
                        stateNext   = SLIP;
                        windowNext  = '0;
                        slipTmrNext = '0;
                        slipCntNext = satInc4(slipCnt);
                    end else begin
                        windowNext = windowCnt + WIN_ONE;
                    end
                end
                SLIP: begin
                    if (slipTmr == SLIP_LAST) begin
                        stateNext   = SETTLE;
                        slipTmrNext = '0;
                    end else begin
                        slipTmrNext = slipTmr + TMR_ONE;
                    end
                end
                SETTLE: begin
                    if (slipTmr == SETTLE_LAST) begin
                        stateNext   = HUNT;
                        slipTmrNext = '0;
                        windowNext  = '0;
                    end else begin
                        slipTmrNext = slipTmr + TMR_ONE;
                    end
                end
                VERIFY: begin
                    // An invalid group outranks a coincident window timeout.
                    if (i_RxCodeInvalid) begin
                        stateNext  = HUNT;
                        windowNext = '0;
                        commaNext  = '0;
                    end else if (goodComma) begin
                        windowNext = '0;
                        if (commaCnt == COMMA_LAST) begin
                            stateNext = SYNCED;
                            commaNext = '0;
                        end else begin
                            commaNext = commaCnt + COMMA_ONE;
                        end
                    end else if (windowCnt == WIN_LAST) begin
                        stateNext   = SLIP;
                        windowNext  = '0;
                        commaNext   = '0;
                        slipTmrNext = '0;
                        slipCntNext = satInc4(slipCnt);
                    end else begin
                        windowNext = windowCnt + WIN_ONE;
                    end
                end
                SYNCED: begin
                    if (monLossReq) begin
                        stateNext     = HUNT;
                        windowNext    = '0;
                        lossPulseNext = 1'b1;
                    end
                end
                default: begin
                    stateNext   = HUNT;
                    windowNext  = '0;
                    commaNext   = '0;
                    slipTmrNext = '0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            state     <= HUNT;
            windowCnt <= '0;
            commaCnt  <= '0;
            slipTmr   <= '0;
            slipCnt   <= '0;
            lossPulse <= 1'b0;
        end else begin
            state     <= stateNext;
            windowCnt <= windowNext;
            commaCnt  <= commaNext;
            slipTmr   <= slipTmrNext;
            slipCnt   <= slipCntNext;
            lossPulse <= lossPulseNext;
        end
    end

    assign o_RxBitSlip    = (state == SLIP);
    assign o_SyncAcquired = (state == SYNCED);
    assign o_LossOfSync   = lossPulse;
    assign o4_SlipCount   = slipCnt;
    assign o3_DbgState    = state;

endmodule

// File: tb/tb_sgmii_rx_word_aligner.sv
// Directed bench for the SGMII receive word aligner, including a small
// behavioural PHY that moves the word boundary one bit per slip pulse.
module tb_sgmii_rx_word_aligner;

    localparam logic [2:0] ST_HUNT   = 3'd0;
    localparam logic [2:0] ST_SLIP   = 3'd1;
    localparam logic [2:0] ST_VERIFY = 3'd3;
    localparam logic [2:0] ST_SYNCED = 3'd4;

    localparam int K_DATA  = 0;
    localparam int K_COMMA = 1;
    localparam int K_ERR   = 2;

    logic       i_Clk;
    logic       i_ARst_L;
    logic       i_Enable;
    logic [7:0] i8_RxCodeGroup;
    logic       i_RxCodeCtrl;
    logic       i_RxCodeInvalid;
    logic       o_RxBitSlip;
    logic       o_SyncAcquired;
    logic       o_LossOfSync;
    logic [3:0] o4_SlipCount;
    logic [2:0] o3_DbgState;

    int nAsserts = 0;
    int nFails   = 0;

    // PHY model and slip-pulse tracking.
    int   cycle     = 0;
    int   phyOffset = 0;
    int   rises     = 0;
    int   lastRise  = -1;
    int   highRun   = 0;
    logic prevSlip  = 1'b0;
    logic trackSlip = 1'b0;

    sgmii_rx_word_aligner dut (
        .i_Clk           (i_Clk),
        .i_ARst_L        (i_ARst_L),
        .i_Enable        (i_Enable),
        .i8_RxCodeGroup  (i8_RxCodeGroup),
        .i_RxCodeCtrl    (i_RxCodeCtrl),
        .i_RxCodeInvalid (i_RxCodeInvalid),
        .o_RxBitSlip     (o_RxBitSlip),
        .o_SyncAcquired  (o_SyncAcquired),
        .o_LossOfSync    (o_LossOfSync),
        .o4_SlipCount    (o4_SlipCount),
        .o3_DbgState     (o3_DbgState)
    );

    // Clock.
    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setGroup(input int kind);
        case (kind)
            K_COMMA: begin i_RxCodeCtrl = 1'b1; i8_RxCodeGroup = 8'hBC; i_RxCodeInvalid = 1'b0; end
            K_ERR:   begin i_RxCodeCtrl = 1'b0; i8_RxCodeGroup = 8'h55; i_RxCodeInvalid = 1'b1; end
            default: begin i_RxCodeCtrl = 1'b0; i8_RxCodeGroup = 8'h4A; i_RxCodeInvalid = 1'b0; end
        endcase
    endtask

    // Advance one clock and sample 1 time unit after the edge; also runs the PHY model.
    task automatic tick();
        @(posedge i_Clk);
        #1;
        cycle++;
        if (o_RxBitSlip && !prevSlip) begin
            rises++;
            if (phyOffset != 0) phyOffset--;
            if (trackSlip && lastRise >= 0) check("slip_spacing_ge_38", 32'(cycle - lastRise >= 38), 32'd1);
            lastRise = cycle;
            highRun  = 0;
        end
        if (o_RxBitSlip) highRun++;
        if (!o_RxBitSlip && prevSlip && trackSlip) check("slip_width", 32'(highRun), 32'd2);
        prevSlip = o_RxBitSlip;
    endtask

    task automatic send(input int kind);
        setGroup(kind);
        tick();
    endtask

    initial begin
        int alt;
        i_ARst_L = 1'b0;
        i_Enable = 1'b1;
        setGroup(K_DATA);

        // Reset state.
        tick();
        tick();
        check("rst_slip",  32'(o_RxBitSlip), 32'd0);
        check("rst_sync",  32'(o_SyncAcquired), 32'd0);
        check("rst_loss",  32'(o_LossOfSync), 32'd0);
        check("rst_count", 32'(o4_SlipCount), 32'd0);
        check("rst_state", 32'(o3_DbgState), 32'(ST_HUNT));
        i_ARst_L = 1'b1;

        // Aligned stream: comma every second group.
        rises = 0;
        send(K_COMMA);
        check("al_verify_1st", 32'(o3_DbgState), 32'(ST_VERIFY));
        send(K_DATA);
        send(K_COMMA);
        check("al_verify_2nd", 32'(o3_DbgState), 32'(ST_VERIFY));
        check("al_nosync_2nd", 32'(o_SyncAcquired), 32'd0);
        send(K_DATA);
        send(K_COMMA);
        check("al_sync", 32'(o_SyncAcquired), 32'd1);
        check("al_state", 32'(o3_DbgState), 32'(ST_SYNCED));
        check("al_no_slip", 32'(rises), 32'd0);
        check("al_count", 32'(o4_SlipCount), 32'd0);

        // Spaced errors: each recovered by four good groups, sync held.
        for (int e = 0; e < 3; e++) begin
            send(K_ERR);
            check("sp_sync_err", 32'(o_SyncAcquired), 32'd1);
            check("sp_loss_err", 32'(o_LossOfSync), 32'd0);
            for (int g = 0; g < 4; g++) begin
                send(K_DATA);
                check("sp_sync_good", 32'(o_SyncAcquired), 32'd1);
                check("sp_loss_good", 32'(o_LossOfSync), 32'd0);
            end
        end

        // Errors at 0,2,4,6: loss on the fourth.
        for (int e = 0; e < 3; e++) begin
            send(K_ERR);
            check("ls_loss_early", 32'(o_LossOfSync), 32'd0);
            send(K_DATA);
            check("ls_sync_early", 32'(o_SyncAcquired), 32'd1);
        end
        send(K_ERR);
        check("ls_loss_pulse", 32'(o_LossOfSync), 32'd1);
        check("ls_sync_drop", 32'(o_SyncAcquired), 32'd0);
        check("ls_state", 32'(o3_DbgState), 32'(ST_HUNT));
        send(K_DATA);
        check("ls_pulse_end", 32'(o_LossOfSync), 32'd0);

        // Invalid group in VERIFY after two commas.
        send(K_COMMA);
        send(K_DATA);
        send(K_COMMA);
        check("vf_verify", 32'(o3_DbgState), 32'(ST_VERIFY));
        send(K_ERR);
        check("vf_hunt", 32'(o3_DbgState), 32'(ST_HUNT));
        check("vf_noslip", 32'(o_RxBitSlip), 32'd0);
        send(K_COMMA);
        send(K_DATA);
        send(K_COMMA);
        send(K_DATA);
        check("vf_nosync_2", 32'(o_SyncAcquired), 32'd0);
        send(K_COMMA);
        check("vf_sync_3", 32'(o_SyncAcquired), 32'd1);
        check("vf_count", 32'(o4_SlipCount), 32'd0);

        // Disable clears back to HUNT without a loss pulse.
        i_Enable = 1'b0;
        send(K_DATA);
        check("dis_state", 32'(o3_DbgState), 32'(ST_HUNT));
        check("dis_loss", 32'(o_LossOfSync), 32'd0);
        i_Enable = 1'b1;

        // Stream misaligned by three bits.
        phyOffset = 3;
        rises     = 0;
        lastRise  = -1;
        trackSlip = 1'b1;
        alt       = 0;
        for (int n = 0; n < 400 && !o_SyncAcquired; n++) begin
            if (phyOffset != 0) begin
                i_RxCodeCtrl    = 1'b0;
                i8_RxCodeGroup  = 8'($urandom_range(0, 255));
                i_RxCodeInvalid = ($urandom_range(0, 3) == 0);
            end else begin
                setGroup(alt == 0 ? K_COMMA : K_DATA);
                alt = 1 - alt;
            end
            tick();
        end
        trackSlip = 1'b0;
        check("ma_sync", 32'(o_SyncAcquired), 32'd1);
        check("ma_slips", 32'(rises), 32'd3);
        check("ma_count", 32'(o4_SlipCount), 32'd3);
        check("ma_offset", 32'(phyOffset), 32'd0);

        // Enable dropped on the second cycle of a slip pulse.
        i_Enable = 1'b0;
        send(K_DATA);
        i_Enable = 1'b1;
        for (int k = 0; k < 31; k++) send(K_DATA);
        check("en_preslip", 32'(o_RxBitSlip), 32'd0);
        check("en_prestate", 32'(o3_DbgState), 32'(ST_HUNT));
        send(K_DATA);
        check("en_slip1", 32'(o_RxBitSlip), 32'd1);
        check("en_slipstate", 32'(o3_DbgState), 32'(ST_SLIP));
        check("en_count1", 32'(o4_SlipCount), 32'd1);
        send(K_DATA);
        check("en_slip2", 32'(o_RxBitSlip), 32'd1);
        i_Enable = 1'b0;
        send(K_DATA);
        check("en_slipdrop", 32'(o_RxBitSlip), 32'd0);
        check("en_count0", 32'(o4_SlipCount), 32'd0);
        check("en_hunt", 32'(o3_DbgState), 32'(ST_HUNT));
        check("en_noloss", 32'(o_LossOfSync), 32'd0);
        i_Enable = 1'b1;
        send(K_COMMA);
        check("en_verify", 32'(o3_DbgState), 32'(ST_VERIFY));
        send(K_DATA);
        send(K_COMMA);
        send(K_DATA);
        send(K_COMMA);
        check("en_sync", 32'(o_SyncAcquired), 32'd1);
        check("en_count_after", 32'(o4_SlipCount), 32'd0);

        // Asynchronous reset in the middle of a slip pulse.
        i_Enable = 1'b0;
        send(K_DATA);
        i_Enable = 1'b1;
        for (int k = 0; k < 32; k++) send(K_DATA);
        check("ar_slip", 32'(o_RxBitSlip), 32'd1);
        #2;
        i_ARst_L = 1'b0;
        #1;
        check("ar_slipdrop", 32'(o_RxBitSlip), 32'd0);
        check("ar_count", 32'(o4_SlipCount), 32'd0);
        check("ar_state", 32'(o3_DbgState), 32'(ST_HUNT));

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
